// File: rtl/ntt_zeta_sequencer.sv
// Zeta ROM reader for the 8-BU forward NTT (n=256). It walks the 7 layers and issues one ROM row per credit,
// then forwards the 8 returned twiddles, in issue order, through a valid/ready FIFO.
module ntt_zeta_sequencer #(
    parameter int DATA_WIDTH = 13,
    parameter int ROM_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4:0]            zeta_addr_o,
    output logic [7:0]            len_o,
    input  logic [DATA_WIDTH-2:0] zeta_rom0_i,
    input  logic [DATA_WIDTH-2:0] zeta_rom1_i,
    input  logic [DATA_WIDTH-2:0] zeta_rom2_i,
    input  logic [DATA_WIDTH-2:0] zeta_rom3_i,
    input  logic [DATA_WIDTH-2:0] zeta_rom4_i,
    input  logic [DATA_WIDTH-2:0] zeta_rom5_i,
    input  logic [DATA_WIDTH-2:0] zeta_rom6_i,
    input  logic [DATA_WIDTH-2:0] zeta_rom7_i,
    output logic                  zeta_valid_o,
    input  logic                  zeta_ready_i,
    output logic [DATA_WIDTH-2:0] zeta0_o,
    output logic [DATA_WIDTH-2:0] zeta1_o,
    output logic [DATA_WIDTH-2:0] zeta2_o,
    output logic [DATA_WIDTH-2:0] zeta3_o,
    output logic [DATA_WIDTH-2:0] zeta4_o,
    output logic [DATA_WIDTH-2:0] zeta5_o,
    output logic [DATA_WIDTH-2:0] zeta6_o,
    output logic [DATA_WIDTH-2:0] zeta7_o,
    output logic [2:0]            zeta_layer_o,
    output logic                  zeta_last_o
);
    localparam int ZW        = DATA_WIDTH - 1;
    localparam int NUM_LANES = 8;
    localparam int CW        = $clog2(FIFO_DEPTH + 1);
    localparam int PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    typedef struct packed {
        logic [2:0] layer;
        logic       last;
    } tag_t;

    typedef struct packed {
        logic [NUM_LANES-1:0][ZW-1:0] zeta;
        tag_t                         tag;
    } word_t;

    logic [1:0]                   state;
    logic [2:0]                   layer_q;
    logic [3:0]                   cyc_q;
    logic                         issue, last_issue, credit;
    logic [ROM_LAT:1]             vld_pipe;
    tag_t [ROM_LAT:1]             tag_pipe;
    logic [CW-1:0]                inflight, fifo_cnt;
    logic [PW-1:0]                wr_ptr, rd_ptr;
    word_t                        mem [FIFO_DEPTH];
    word_t                        head, out_word;
    logic                         push, pop, empty;
    logic [4:0]                   row;
    logic [NUM_LANES-1:0][ZW-1:0] rom_bus;

    assign rom_bus = {zeta_rom7_i, zeta_rom6_i, zeta_rom5_i, zeta_rom4_i,
                      zeta_rom3_i, zeta_rom2_i, zeta_rom1_i, zeta_rom0_i};

    // Later layers use more distinct twiddles per layer, so several rows per layer.
    always_comb begin
        case (layer_q)
            3'd4:    row = 5'd4  + {4'd0, cyc_q[3]};
            3'd5:    row = 5'd6  + {3'd0, cyc_q[3:2]};
            3'd6:    row = 5'd10 + {2'd0, cyc_q[3:1]};
            default: row = {2'd0, layer_q};
        endcase
    end

    assign zeta_addr_o = row;
    assign len_o       = (state == S_ISSUE) ? (8'd128 >> layer_q) : 8'd0;
    assign busy_o      = (state != S_IDLE);

    always_comb begin
        inflight = '0;
        for (int i = 1; i <= ROM_LAT; i++) inflight = inflight + CW'(vld_pipe[i]);
    end

    // Every outstanding ROM read owns a FIFO slot, so capture can never overflow.
    assign credit     = ({1'b0, fifo_cnt} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);
    assign issue      = (state == S_ISSUE) && credit;
    assign last_issue = (layer_q == 3'd6) && (cyc_q == 4'd15);

    assign push  = vld_pipe[ROM_LAT];
    assign empty = (fifo_cnt == '0);
    assign pop   = !empty && zeta_ready_i;
    assign head  = mem[rd_ptr];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            layer_q <= '0;
            cyc_q   <= '0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: if (start_i) state <= S_ISSUE;
                S_ISSUE: if (issue) begin
                    if (last_issue) begin
                        state   <= S_DRAIN;
                        layer_q <= '0;
                        cyc_q   <= '0;
                    end else begin
                        cyc_q <= cyc_q + 4'd1;
                        if (cyc_q == 4'd15) layer_q <= layer_q + 3'd1;
                    end
                end
                S_DRAIN: if (pop && head.tag.last) begin
                    state  <= S_IDLE;
                    done_o <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe[1] <= issue;
            tag_pipe[1] <= '{layer: layer_q, last: last_issue};
            for (int i = 2; i <= ROM_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= '{zeta: rom_bus, tag: tag_pipe[ROM_LAT]};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) assert (!(push && !pop && fifo_cnt == CW'(FIFO_DEPTH)));
    end

    assign out_word     = empty ? '0 : head;
    assign zeta_valid_o = !empty;
    assign zeta_layer_o = out_word.tag.layer;
    assign zeta_last_o  = out_word.tag.last;
    assign zeta0_o      = out_word.zeta[0];
    assign zeta1_o      = out_word.zeta[1];
    assign zeta2_o      = out_word.zeta[2];
    assign zeta3_o      = out_word.zeta[3];
    assign zeta4_o      = out_word.zeta[4];
    assign zeta5_o      = out_word.zeta[5];
    assign zeta6_o      = out_word.zeta[6];
    assign zeta7_o      = out_word.zeta[7];
endmodule

// File: tb/tb_ntt_zeta_sequencer.sv
// Scoreboard bench: two sequencers (ROM latency 1 and 3) each read a modelled ROM; expected words are queued at
// start and popped by a monitor on every handshake.
module tb_ntt_zeta_sequencer;
    localparam int ZW = 12;

    typedef struct packed {
        logic [7:0][ZW-1:0] z;
        logic [2:0]         layer;
        logic               last;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    int e0 = 0, hold_lo = 0, hold_hi = -1;
    bit rand_b = 1'b0;
    int seen [2], dones [2], first_cyc [2], done_cyc [2];
    exp_t qa [$];
    exp_t qb [$];

    logic busy_a, done_a, vld_a, rdy_a, last_a, busy_b, done_b, vld_b, rdy_b, last_b;
    logic [4:0] addr_a, addr_b;
    logic [7:0] len_a, len_b;
    logic [2:0] lay_a, lay_b;
    logic [7:0][ZW-1:0] za, zb, ra, rb;

    function automatic logic [ZW-1:0] rom_f(input int a, input int l, input int k);
        return ZW'((1729 + (a * 8 + k) * 97 + (128 - l) * 31) % 3329);
    endfunction

    // Word w of the sequence: layer w/16, position w%16; later layers spread over more rows.
    function automatic exp_t exp_word(input int w);
        exp_t e;
        int L, c, r, len;
        L = w / 16;
        c = w % 16;
        if (L < 4)       r = L;
        else if (L == 4) r = 4 + c / 8;
        else if (L == 5) r = 6 + c / 4;
        else             r = 10 + c / 2;
        len = 128 >> L;
        for (int k = 0; k < 8; k++) e.z[k] = rom_f(r, len, k);
        e.layer = 3'(L);
        e.last  = (w == 111);
        return e;
    endfunction

    // ROM models: data reflects the address presented ROM_LAT cycles earlier.
    logic [4:0] pa, pb0, pb1, pb2;
    logic [7:0] la, lb0, lb1, lb2;
    always @(posedge clk) begin
        pa <= addr_a; la <= len_a;
        pb0 <= addr_b; lb0 <= len_b; pb1 <= pb0; lb1 <= lb0; pb2 <= pb1; lb2 <= lb1;
    end
    always_comb begin
        ra = '0;
        rb = '0;
        for (int k = 0; k < 8; k++) begin
            ra[k] = rom_f(int'(pa), int'(la), k);
            rb[k] = rom_f(int'(pb2), int'(lb2), k);
        end
    end

    ntt_zeta_sequencer #(.DATA_WIDTH(13), .ROM_LAT(1), .FIFO_DEPTH(4)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy_a), .done_o(done_a),
        .zeta_addr_o(addr_a), .len_o(len_a),
        .zeta_rom0_i(ra[0]), .zeta_rom1_i(ra[1]), .zeta_rom2_i(ra[2]), .zeta_rom3_i(ra[3]),
        .zeta_rom4_i(ra[4]), .zeta_rom5_i(ra[5]), .zeta_rom6_i(ra[6]), .zeta_rom7_i(ra[7]),
        .zeta_valid_o(vld_a), .zeta_ready_i(rdy_a),
        .zeta0_o(za[0]), .zeta1_o(za[1]), .zeta2_o(za[2]), .zeta3_o(za[3]),
        .zeta4_o(za[4]), .zeta5_o(za[5]), .zeta6_o(za[6]), .zeta7_o(za[7]),
        .zeta_layer_o(lay_a), .zeta_last_o(last_a)
    );

    ntt_zeta_sequencer #(.DATA_WIDTH(13), .ROM_LAT(3), .FIFO_DEPTH(4)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy_b), .done_o(done_b),
        .zeta_addr_o(addr_b), .len_o(len_b),
        .zeta_rom0_i(rb[0]), .zeta_rom1_i(rb[1]), .zeta_rom2_i(rb[2]), .zeta_rom3_i(rb[3]),
        .zeta_rom4_i(rb[4]), .zeta_rom5_i(rb[5]), .zeta_rom6_i(rb[6]), .zeta_rom7_i(rb[7]),
        .zeta_valid_o(vld_b), .zeta_ready_i(rdy_b),
        .zeta0_o(zb[0]), .zeta1_o(zb[1]), .zeta2_o(zb[2]), .zeta3_o(zb[3]),
        .zeta4_o(zb[4]), .zeta5_o(zb[5]), .zeta6_o(zb[6]), .zeta7_o(zb[7]),
        .zeta_layer_o(lay_b), .zeta_last_o(last_b)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon(input int id, input logic vld, input logic rdy, input logic dn,
                       input logic bsy, input exp_t got);
        exp_t e;
        int qs;
        qs = (id == 0) ? qa.size() : qb.size();
        if (vld) begin
            if (qs == 0) chk($sformatf("unexpected_word%0d", id), 1, 0);
            else begin
                e = (id == 0) ? qa[0] : qb[0];
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL word%0d[%0d]: got %h expected %h", id, seen[id], got, e);
                end
                if (first_cyc[id] < 0) first_cyc[id] = cyc;
                if (rdy) begin
                    if (id == 0) void'(qa.pop_front());
                    else void'(qb.pop_front());
                    seen[id]++;
                end
            end
        end
        if (dn) begin
            dones[id]++;
            done_cyc[id] = cyc;
            chk($sformatf("done_q_empty%0d", id), (id == 0) ? qa.size() : qb.size(), 0);
            chk($sformatf("busy_at_done%0d", id), bsy, 0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, vld_a, rdy_a, done_a, busy_a, {za, lay_a, last_a});
        mon(1, vld_b, rdy_b, done_b, busy_b, {zb, lay_b, last_b});
    end

    always begin
        @(posedge clk);
        #1;
        rdy_a = (cyc >= hold_lo && cyc <= hold_hi) ? 1'b0 : 1'b1;
        rdy_b = rand_b ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic clear_sb();
        qa.delete();
        qb.delete();
        for (int i = 0; i < 2; i++) begin
            seen[i] = 0; dones[i] = 0; first_cyc[i] = -1; done_cyc[i] = -1;
        end
    endtask

    task automatic start_seq(input bit fresh);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (fresh) begin
            e0 = cyc;
            clear_sb();
            for (int w = 0; w < 112; w++) begin
                qa.push_back(exp_word(w));
                qb.push_back(exp_word(w));
            end
        end
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 4000 && !(dones[0] > 0 && dones[1] > 0); i++) @(posedge clk);
        if (i >= 4000) chk("done_timeout", 0, 1);
        repeat (4) @(posedge clk);
    endtask

    task automatic end_checks(input string t);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_words%0d", t, i), seen[i], 112);
            chk($sformatf("%s_dones%0d", t, i), dones[i], 1);
        end
        chk({t, "_qa_left"}, qa.size(), 0);
        chk({t, "_qb_left"}, qb.size(), 0);
    endtask

    initial begin
        clear_sb();
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {busy_a, busy_b}, 0);
        chk("rst_done", {done_a, done_b}, 0);
        chk("rst_valid", {vld_a, vld_b}, 0);
        chk("rst_addr", {addr_a, addr_b}, 0);
        chk("rst_len", {len_a, len_b}, 0);
        chk("rst_zeta", {za, zb}, 0);
        chk("rst_tag", {lay_a, last_a, lay_b, last_b}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Ready high on the latency-1 unit: full throughput and exact timing.
        rand_b = 1'b1;
        start_seq(1'b1);
        wait_done();
        chk("lat1_first_valid", first_cyc[0] - e0, 2);
        chk("lat1_done_cycle", done_cyc[0] - e0, 114);
        chk("lat3_first_valid_min", (first_cyc[1] - e0) >= 4, 1);
        end_checks("t1");

        // Backpressure window plus a start pulse while busy.
        start_seq(1'b1);
        hold_lo = e0 + 5;
        hold_hi = e0 + 20;
        repeat (25) @(posedge clk);
        chk("t6_busy_before_pulse", {busy_a, busy_b}, 2'b11);
        start_seq(1'b0);
        wait_done();
        hold_hi = -1;
        end_checks("t3");

        // Reset in the middle of a sequence, then a fresh replay.
        start_seq(1'b1);
        for (int i = 0; i < 2000 && seen[0] < 40; i++) @(posedge clk);
        chk("t5_reached_40", seen[0] >= 40, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        clear_sb();
        @(negedge clk);
        chk("t5_valid_after_rst", {vld_a, vld_b}, 0);
        chk("t5_busy_after_rst", {busy_a, busy_b}, 0);
        repeat (20) @(posedge clk);
        chk("t5_no_done", dones[0] + dones[1], 0);
        start_seq(1'b1);
        wait_done();
        chk("t5_replay_first_valid", first_cyc[0] - e0, 2);
        end_checks("t5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
